// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment message-scroll path.
//   mode_e             : scroll mode encodings (11 is reserved and acts as hold)
//   DEFAULT_BLANK_CODE : character-ROM code that lights no segments
//   idx_w()            : index width for a buffer of the given depth (min 1)
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_WRAP   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam int DEFAULT_BLANK_CODE = 35;

    // Width of an index into a buffer of 'depth' entries; never below 1 bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/seg_window_mux.sv
// ---------------------------------------------------------------------------
// seg_window_mux
// Purely combinational window selector. Picks NUM_DIGITS consecutive codes
// out of the flattened message buffer starting at 'offset', wrapping modulo
// msg_len. Short messages (msg_len <= NUM_DIGITS) are shown left-aligned
// from entry 0 with the remaining digits blanked.
// Ports:
//   offset   in  AW                    window start index
//   msg_len  in  LW                    active message length (1..MSG_DEPTH)
//   buf_flat in  MSG_DEPTH*CHAR_W      buffer, entry k at bits [k*CHAR_W +: CHAR_W]
//   codes    out NUM_DIGITS*CHAR_W     digit 0 (leftmost) in the MS slice
// ---------------------------------------------------------------------------
module seg_window_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 16,
    parameter int CHAR_W     = 7,
    parameter int BLANK_CODE = DEFAULT_BLANK_CODE,
    localparam int AW        = idx_w(MSG_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic [AW-1:0]                offset,
    input  logic [LW-1:0]                msg_len,
    input  logic [MSG_DEPTH*CHAR_W-1:0]  buf_flat,
    output logic [NUM_DIGITS*CHAR_W-1:0] codes
);

    // One extra bit so offset + digit index (< 2*MSG_DEPTH) cannot overflow.
    localparam int SW = LW + 1;
    localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(BLANK_CODE);

    always_comb begin
        logic [SW-1:0] sum;
        logic [SW-1:0] idx;
        // NOTE: every output and temporary gets a default before the loop so
        // no path through the block leaves a value held, which would infer a latch.
        codes = {NUM_DIGITS{BLANK}};
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (msg_len > LW'(NUM_DIGITS)) begin
                // offset < msg_len and i < msg_len, so one conditional
                // subtract is a complete modulo.
                sum = SW'(offset) + SW'(i);
                idx = (sum >= SW'(msg_len)) ? sum - SW'(msg_len) : sum;
                codes[(NUM_DIGITS-1-i)*CHAR_W +: CHAR_W] = buf_flat[int'(idx)*CHAR_W +: CHAR_W];
            end else if (LW'(i) < msg_len) begin
                codes[(NUM_DIGITS-1-i)*CHAR_W +: CHAR_W] = buf_flat[i*CHAR_W +: CHAR_W];
            end
        end
    end

endmodule

// File: rtl/seg_scroll_engine.sv
// ---------------------------------------------------------------------------
// seg_scroll_engine
// Message-scroll engine for the seven-segment display. Holds a writable
// buffer of character-ROM codes and presents a NUM_DIGITS-wide window that
// steps on each slowdown tick in hold, wrap or bounce mode.
// Ports:
//   clk        in  1                   clock
//   rst        in  1                   synchronous active-high reset
//   tick       in  1                   one-cycle scroll-step enable
//   dir        in  1                   1 = offset increments, 0 = decrements
//   mode       in  2                   00 hold, 01 wrap, 10 bounce, 11 hold
//   wr_en      in  1                   write one buffer entry
//   wr_addr    in  AW                  buffer write index (>= MSG_DEPTH ignored)
//   wr_data    in  CHAR_W              buffer write code
//   len_wr     in  1                   load message length (wins over tick)
//   len_data   in  AW+1                requested length, clamped to 1..MSG_DEPTH
//   char_codes out NUM_DIGITS*CHAR_W   registered window, digit 0 in MS slice
//   offset     out AW                  current window start index
//   wrap_pulse out 1                   pulse on wrap or bounce reversal
// ---------------------------------------------------------------------------
module seg_scroll_engine
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 16,
    parameter int CHAR_W     = 7,
    parameter int BLANK_CODE = DEFAULT_BLANK_CODE,
    localparam int AW        = idx_w(MSG_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         dir,
    input  logic [1:0]                   mode,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [CHAR_W-1:0]            wr_data,
    input  logic                         len_wr,
    input  logic [LW-1:0]                len_data,
    output logic [NUM_DIGITS*CHAR_W-1:0] char_codes,
    output logic [AW-1:0]                offset,
    output logic                         wrap_pulse
);

    localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(BLANK_CODE);

    logic [MSG_DEPTH*CHAR_W-1:0]  msg_buf;
    logic [LW-1:0]                msg_len;
    logic                         bdir;
    logic                         in_bounce;   // mode was bounce last cycle
    logic [NUM_DIGITS*CHAR_W-1:0] window;

    mode_e         mode_q;
    logic          frozen;
    logic          enter_bounce;
    logic [LW-1:0] max_off;
    logic [LW-1:0] off_ext;
    logic [LW-1:0] len_clamped;

    always_comb begin
        mode_q       = mode_e'(mode);
        frozen       = (msg_len <= LW'(NUM_DIGITS));
        enter_bounce = (mode_q == MODE_BOUNCE) && !in_bounce;
        max_off      = msg_len - LW'(NUM_DIGITS);
        off_ext      = LW'(offset);
        if (len_data == '0)
            len_clamped = LW'(1);
        else if (len_data > LW'(MSG_DEPTH))
            len_clamped = LW'(MSG_DEPTH);
        else
            len_clamped = len_data;
    end

    seg_window_mux #(
        .NUM_DIGITS (NUM_DIGITS),
        .MSG_DEPTH  (MSG_DEPTH),
        .CHAR_W     (CHAR_W),
        .BLANK_CODE (BLANK_CODE)
    ) u_window_mux (
        .offset   (offset),
        .msg_len  (msg_len),
        .buf_flat (msg_buf),
        .codes    (window)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the message buffer is cleared on reset on purpose: a reset
            // mid-scroll must blank the display, not replay the old text.
            msg_buf    <= {MSG_DEPTH{BLANK}};
            msg_len    <= LW'(NUM_DIGITS);
            offset     <= '0;
            bdir       <= 1'b1;
            in_bounce  <= 1'b0;
            char_codes <= {NUM_DIGITS{BLANK}};
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            in_bounce  <= (mode_q == MODE_BOUNCE);
            // Window reflects the state as it stood before this edge.
            char_codes <= window;

            if (wr_en && (int'(wr_addr) < MSG_DEPTH))
                msg_buf[int'(wr_addr)*CHAR_W +: CHAR_W] <= wr_data;

            if (len_wr) begin
                msg_len <= len_clamped;
                offset  <= '0;
                bdir    <= dir;
            end else if (frozen) begin
                offset <= '0;
                if (enter_bounce)
                    bdir <= dir;
            end else if (enter_bounce) begin
                // Entry cycle only aligns state; the first step waits for the next tick.
                bdir <= dir;
                if (off_ext > max_off)
                    offset <= AW'(max_off);
            end else if (tick) begin
                unique case (mode_q)
                    MODE_WRAP: begin
                        if (dir) begin
                            if (off_ext == msg_len - LW'(1)) begin
                                offset     <= '0;
                                wrap_pulse <= 1'b1;
                            end else begin
                                offset <= offset + AW'(1);
                            end
                        end else begin
                            if (offset == '0) begin
                                offset     <= AW'(msg_len - LW'(1));
                                wrap_pulse <= 1'b1;
                            end else begin
                                offset <= offset - AW'(1);
                            end
                        end
                    end
                    MODE_BOUNCE: begin
                        // max_off >= 1 here, so reversing always has room to step.
                        if (bdir) begin
                            if (off_ext >= max_off) begin
                                bdir       <= 1'b0;
                                offset     <= AW'(max_off - LW'(1));
                                wrap_pulse <= 1'b1;
                            end else begin
                                offset <= offset + AW'(1);
                            end
                        end else begin
                            if (offset == '0) begin
                                bdir       <= 1'b1;
                                offset     <= AW'(1);
                                wrap_pulse <= 1'b1;
                            end else begin
                                offset <= offset - AW'(1);
                            end
                        end
                    end
                    default: begin
                        offset <= offset;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scroll_engine.sv
// ---------------------------------------------------------------------------
// tb_seg_scroll_engine
// Directed bench for seg_scroll_engine. Built with MSG_DEPTH = 12 so that
// 4-bit write addresses 12..15 are out of range and the length clamp is
// reachable with a 5-bit len_data.
// ---------------------------------------------------------------------------
module tb_seg_scroll_engine;

    localparam int ND = 4;
    localparam int MD = 12;
    localparam int CW = 7;
    localparam int BL = 35;
    localparam int AW = 4;
    localparam int LW = 5;

    logic                 clk;
    logic                 rst;
    logic                 tick;
    logic                 dir;
    logic [1:0]           mode;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [CW-1:0]        wr_data;
    logic                 len_wr;
    logic [LW-1:0]        len_data;
    logic [ND*CW-1:0]     char_codes;
    logic [AW-1:0]        offset;
    logic                 wrap_pulse;

    int n_tests;
    int n_failed;

    seg_scroll_engine #(
        .NUM_DIGITS (ND),
        .MSG_DEPTH  (MD),
        .CHAR_W     (CW),
        .BLANK_CODE (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .dir        (dir),
        .mode       (mode),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .len_wr     (len_wr),
        .len_data   (len_data),
        .char_codes (char_codes),
        .offset     (offset),
        .wrap_pulse (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ND*CW-1:0] win(input int d0, input int d1, input int d2, input int d3);
        return {CW'(d0), CW'(d1), CW'(d2), CW'(d3)};
    endfunction

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = CW'(data);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic load_len(input int len, input logic d);
        len_wr   = 1'b1;
        len_data = LW'(len);
        dir      = d;
        step();
        len_wr   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_tests++;
        if (char_codes !== win(BL, BL, BL, BL)) begin
            n_failed++;
            $display("FAIL reset_codes: got %h expected %h", char_codes, win(BL, BL, BL, BL));
        end
        n_tests++;
        if (offset !== 4'd0) begin
            n_failed++;
            $display("FAIL reset_offset: got %0d expected 0", offset);
        end
        n_tests++;
        if (wrap_pulse !== 1'b0) begin
            n_failed++;
            $display("FAIL reset_pulse: got %b expected 0", wrap_pulse);
        end
        // Default length equals the window width, so scrolling stays frozen.
        mode = 2'b01;
        dir  = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_tests++;
        if (offset !== 4'd0 || wrap_pulse !== 1'b0) begin
            n_failed++;
            $display("FAIL frozen_tick: got offset %0d pulse %b expected 0 0", offset, wrap_pulse);
        end
    endtask

    task automatic test_wrap_left();
        logic [ND*CW-1:0] exp_win [6];
        int               exp_off [6];
        exp_win[0] = win(22, 16, 27, 0);
        exp_win[1] = win(16, 27, 0, 29);
        exp_win[2] = win(27, 0, 29, 22);
        exp_win[3] = win(0, 29, 22, 16);
        exp_win[4] = win(29, 22, 16, 27);
        exp_win[5] = win(22, 16, 27, 0);
        exp_off[0] = 0; exp_off[1] = 1; exp_off[2] = 2;
        exp_off[3] = 3; exp_off[4] = 4; exp_off[5] = 0;
        write_entry(0, 22);
        write_entry(1, 16);
        write_entry(2, 27);
        write_entry(3, 0);
        write_entry(4, 29);
        mode = 2'b01;
        load_len(5, 1'b1);
        step();
        n_tests++;
        if (char_codes !== exp_win[0]) begin
            n_failed++;
            $display("FAIL wrap_left_win0: got %h expected %h", char_codes, exp_win[0]);
        end
        for (int k = 1; k <= 5; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            n_tests++;
            if (offset !== AW'(exp_off[k]) || wrap_pulse !== (k == 5)) begin
                n_failed++;
                $display("FAIL wrap_left_tick%0d: got offset %0d pulse %b expected %0d %b",
                         k, offset, wrap_pulse, exp_off[k], (k == 5));
            end
            step();
            n_tests++;
            if (char_codes !== exp_win[k] || wrap_pulse !== 1'b0) begin
                n_failed++;
                $display("FAIL wrap_left_win%0d: got %h pulse %b expected %h 0",
                         k, char_codes, wrap_pulse, exp_win[k]);
            end
        end
    endtask

    task automatic test_wrap_right();
        dir  = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_tests++;
        if (offset !== 4'd4 || wrap_pulse !== 1'b1) begin
            n_failed++;
            $display("FAIL wrap_right_tick: got offset %0d pulse %b expected 4 1", offset, wrap_pulse);
        end
        step();
        n_tests++;
        if (char_codes !== win(29, 22, 16, 27)) begin
            n_failed++;
            $display("FAIL wrap_right_win: got %h expected %h", char_codes, win(29, 22, 16, 27));
        end
    endtask

    task automatic test_bounce();
        int   exp_off [5];
        logic exp_pl  [5];
        exp_off[0] = 1; exp_off[1] = 2; exp_off[2] = 1; exp_off[3] = 0; exp_off[4] = 1;
        exp_pl[0]  = 0; exp_pl[1]  = 0; exp_pl[2]  = 1; exp_pl[3]  = 0; exp_pl[4]  = 1;
        mode = 2'b01;
        load_len(6, 1'b1);
        // Entry cycle with tick high must not step.
        mode = 2'b10;
        tick = 1'b1;
        step();
        n_tests++;
        if (offset !== 4'd0 || wrap_pulse !== 1'b0) begin
            n_failed++;
            $display("FAIL bounce_entry: got offset %0d pulse %b expected 0 0", offset, wrap_pulse);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++;
            if (offset !== AW'(exp_off[k]) || wrap_pulse !== exp_pl[k]) begin
                n_failed++;
                $display("FAIL bounce_tick%0d: got offset %0d pulse %b expected %0d %b",
                         k + 1, offset, wrap_pulse, exp_off[k], exp_pl[k]);
            end
        end
        tick = 1'b0;
        step();
        n_tests++;
        if (char_codes !== win(16, 27, 0, 29)) begin
            n_failed++;
            $display("FAIL bounce_win: got %h expected %h", char_codes, win(16, 27, 0, 29));
        end
    endtask

    task automatic test_bounce_clamp();
        // Wrap forward from 1 to 4, then enter bounce: offset clamps to MAX = 2.
        mode = 2'b01;
        dir  = 1'b1;
        tick = 1'b1;
        step();
        step();
        step();
        n_tests++;
        if (offset !== 4'd4) begin
            n_failed++;
            $display("FAIL clamp_setup: got offset %0d expected 4", offset);
        end
        mode = 2'b10;
        dir  = 1'b0;
        step();
        n_tests++;
        if (offset !== 4'd2 || wrap_pulse !== 1'b0) begin
            n_failed++;
            $display("FAIL clamp_entry: got offset %0d pulse %b expected 2 0", offset, wrap_pulse);
        end
        step();
        tick = 1'b0;
        n_tests++;
        if (offset !== 4'd1) begin
            n_failed++;
            $display("FAIL clamp_step: got offset %0d expected 1", offset);
        end
    endtask

    task automatic test_len_zero();
        mode     = 2'b01;
        dir      = 1'b1;
        tick     = 1'b1;
        len_wr   = 1'b1;
        len_data = '0;
        step();
        len_wr   = 1'b0;
        tick     = 1'b0;
        n_tests++;
        if (offset !== 4'd0 || wrap_pulse !== 1'b0) begin
            n_failed++;
            $display("FAIL len_zero_offset: got offset %0d pulse %b expected 0 0", offset, wrap_pulse);
        end
        step();
        n_tests++;
        if (char_codes !== win(22, BL, BL, BL)) begin
            n_failed++;
            $display("FAIL len_zero_win: got %h expected %h", char_codes, win(22, BL, BL, BL));
        end
    endtask

    task automatic test_len_clamp();
        // 31 clamps to 12; a backward wrap then lands on entry 11 (blank).
        mode = 2'b01;
        load_len(31, 1'b0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_tests++;
        if (offset !== 4'd11 || wrap_pulse !== 1'b1) begin
            n_failed++;
            $display("FAIL len_clamp_tick: got offset %0d pulse %b expected 11 1", offset, wrap_pulse);
        end
        step();
        n_tests++;
        if (char_codes !== win(BL, 22, 16, 27)) begin
            n_failed++;
            $display("FAIL len_clamp_win: got %h expected %h", char_codes, win(BL, 22, 16, 27));
        end
    endtask

    task automatic test_write_mid();
        mode = 2'b01;
        load_len(5, 1'b1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        n_tests++;
        if (offset !== 4'd1 || char_codes !== win(16, 27, 0, 29)) begin
            n_failed++;
            $display("FAIL write_setup: got offset %0d codes %h expected 1 %h",
                     offset, char_codes, win(16, 27, 0, 29));
        end
        write_entry(2, 9);
        n_tests++;
        if (offset !== 4'd1 || char_codes !== win(16, 27, 0, 29)) begin
            n_failed++;
            $display("FAIL write_same_cycle: got offset %0d codes %h expected 1 %h",
                     offset, char_codes, win(16, 27, 0, 29));
        end
        step();
        n_tests++;
        if (offset !== 4'd1 || char_codes !== win(16, 9, 0, 29)) begin
            n_failed++;
            $display("FAIL write_visible: got offset %0d codes %h expected 1 %h",
                     offset, char_codes, win(16, 9, 0, 29));
        end
        write_entry(13, 5);
        write_entry(12, 6);
        step();
        n_tests++;
        if (offset !== 4'd1 || char_codes !== win(16, 9, 0, 29)) begin
            n_failed++;
            $display("FAIL write_out_of_range: got offset %0d codes %h expected 1 %h",
                     offset, char_codes, win(16, 9, 0, 29));
        end
    endtask

    task automatic test_reset_mid_scroll();
        tick = 1'b1;
        step();
        tick = 1'b0;
        rst  = 1'b1;
        step();
        rst  = 1'b0;
        n_tests++;
        if (offset !== 4'd0 || wrap_pulse !== 1'b0 || char_codes !== win(BL, BL, BL, BL)) begin
            n_failed++;
            $display("FAIL rst_mid_state: got offset %0d pulse %b codes %h expected 0 0 %h",
                     offset, wrap_pulse, char_codes, win(BL, BL, BL, BL));
        end
        step();
        n_tests++;
        if (char_codes !== win(BL, BL, BL, BL)) begin
            n_failed++;
            $display("FAIL rst_mid_buffer: got %h expected %h", char_codes, win(BL, BL, BL, BL));
        end
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst      = 1'b1;
        tick     = 1'b0;
        dir      = 1'b1;
        mode     = 2'b00;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        len_wr   = 1'b0;
        len_data = '0;

        test_reset();
        test_wrap_left();
        test_wrap_right();
        test_bounce();
        test_bounce_clamp();
        test_len_zero();
        test_len_clamp();
        test_write_mid();
        test_reset_mid_scroll();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
